// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - default address/instruction widths, reset PC and sequential PC step
//   - opcode field position inside an instruction word
//   - fetch FSM state encoding (BOOT=0, RUN=1)
package instr_fetch_pkg;

  localparam int          IF_ADDR_W   = 32;
  localparam int          IF_DATA_W   = 32;
  localparam int          IF_PC_STEP  = 4;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  localparam int IF_OPC_HI = 31;
  localparam int IF_OPC_LO = 26;

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic [IF_OPC_HI-IF_OPC_LO:0] opcode_of(input logic [31:0] ins);
    return ins[IF_OPC_HI:IF_OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO of {instr, pc} entries.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   push, din   enqueue din (accepted when not full, or when full with a pop)
//   pop, dout   dequeue head; dout is the head entry (combinational read)
//   flush       empties the queue; overrides push and pop
//   count       number of valid entries (0..QDEPTH)
//   full, empty occupancy flags
module fetch_queue #(
  parameter int QDEPTH = 2,
  parameter int W      = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(QDEPTH):0]  count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(QDEPTH);

  logic [W-1:0]  mem [QDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == (AW+1)'(QDEPTH));
  assign empty = (count == '0);

  // A full queue still accepts a push when the head leaves in the same cycle;
  // the write lands in the slot being vacated, which is read before the edge.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries data only and is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage driving the read port of the unified MEM.
// Owns the PC, prefetches sequential words into a small queue and hands them
// to decode over a valid/ready handshake. Yields MEM to the data stage while
// mem_busy is high and restarts from redirect_pc on a taken branch/jump.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   mem_addr, mem_read         MEM read request (mem_addr is always fetch_pc)
//   mem_data                   MEM read data, valid in the same cycle
//   mem_busy                   data stage owns MEM this cycle
//   redirect, redirect_pc      flush and restart at redirect_pc (word aligned)
//   instr, instr_pc            queue head instruction and its PC
//   instr_valid, instr_ready   handshake to decode
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W      = IF_ADDR_W,
  parameter int                DATA_W      = IF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(IF_RESET_PC),
  parameter int                PC_STEP     = IF_PC_STEP,
  parameter int                QDEPTH      = 2,
  parameter int                BOOT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_busy,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int QW  = DATA_W + ADDR_W;
  localparam int CW  = $clog2(QDEPTH) + 1;
  localparam int BCW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  logic [0:0]        state;
  logic [BCW-1:0]    boot_cnt;
  logic              boot_done;
  logic [ADDR_W-1:0] fetch_pc;
  logic              pop;
  logic              has_space;

  logic [QW-1:0]     q_dout;
  logic [CW-1:0]     q_count;
  logic              q_empty;
  logic              q_full_unused;

  logic [QW-1:0]     hold_p0;
  logic [QW-1:0]     head;

  assign boot_done = (boot_cnt == BCW'(BOOT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_BOOT;
      boot_cnt <= '0;
      fetch_pc <= RESET_PC;
    end else begin
      if (state == ST_BOOT) begin
        boot_cnt <= boot_cnt + 1'b1;
        if (boot_done) state <= ST_RUN;
      end
      // Redirect wins over a sequential advance, also in BOOT or under mem_busy.
      if (redirect)      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (mem_read) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
    end
  end

  assign mem_addr    = fetch_pc;
  assign instr_valid = !q_empty;
  assign pop         = instr_valid && instr_ready;
  assign has_space   = (q_count < CW'(QDEPTH));
  assign mem_read    = (state == ST_RUN) && !mem_busy && !redirect && (has_space || pop);

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .W      (QW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (mem_read),
    .pop   (pop),
    .flush (redirect),
    .din   ({mem_data, fetch_pc}),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full_unused),
    .empty (q_empty)
  );

  // ---- stage p0: last presented head, so instr/instr_pc hold when empty ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_p0 <= '0;
    else      hold_p0 <= head;
  end

  assign head     = q_empty ? hold_p0 : q_dout;
  assign instr    = head[QW-1:ADDR_W];
  assign instr_pc = head[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_data;
  logic        mem_busy;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int checks;
  int errors;

  instr_fetch #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .RESET_PC    (32'h0),
    .PC_STEP     (4),
    .QDEPTH      (2),
    .BOOT_CYCLES (1)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .mem_addr    (mem_addr),
    .mem_read    (mem_read),
    .mem_data    (mem_data),
    .mem_busy    (mem_busy),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  // MEM model: combinational read data
  assign mem_data = mem_addr ^ 32'hA5A50000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_busy = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_read: got %0b want 0", mem_read); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 00000000", mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 00000000", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 00000000", instr_pc); end
    rst_n = 1'b1;
    #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL boot_read c0: got %0b want 0", mem_read); end
  endtask

  task automatic test_stream;
    logic [31:0] ea;
    logic [31:0] ep;
    for (int c = 1; c <= 4; c++) begin
      tick(); #1;
      ea = 32'(4 * (c - 1));
      ep = 32'(4 * (c - 2));
      checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL stream_read c%0d: got %0b want 1", c, mem_read); end
      checks++; if (mem_addr !== ea) begin errors++; $display("FAIL stream_addr c%0d: got %h want %h", c, mem_addr, ea); end
      checks++; if (instr_valid !== (c >= 2)) begin errors++; $display("FAIL stream_valid c%0d: got %0b want %0b", c, instr_valid, (c >= 2)); end
      if (c >= 2) begin
        checks++; if (instr_pc !== ep) begin errors++; $display("FAIL stream_pc c%0d: got %h want %h", c, instr_pc, ep); end
        checks++; if (instr !== (ep ^ 32'hA5A50000)) begin errors++; $display("FAIL stream_instr c%0d: got %h want %h", c, instr, ep ^ 32'hA5A50000); end
      end
    end
  endtask

  task automatic test_mem_busy;
    // cycle 5: fetch_pc=16, queue holds pc 12
    tick();
    mem_busy = 1'b1;
    #1;
    checks++; if (mem_addr !== 32'd16) begin errors++; $display("FAIL busy_addr0: got %h want 00000010", mem_addr); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL busy_read0: got %0b want 0", mem_read); end
    checks++; if (instr_pc !== 32'd12 || instr_valid !== 1'b1) begin errors++; $display("FAIL busy_head0: got pc %h v %0b want 0000000c v 1", instr_pc, instr_valid); end
    for (int k = 1; k <= 2; k++) begin
      tick(); #1;
      checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL busy_read%0d: got %0b want 0", k, mem_read); end
      checks++; if (mem_addr !== 32'd16) begin errors++; $display("FAIL busy_addr%0d: got %h want 00000010", k, mem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL busy_valid%0d: got %0b want 0", k, instr_valid); end
      checks++; if (instr_pc !== 32'd12) begin errors++; $display("FAIL busy_hold%0d: got %h want 0000000c", k, instr_pc); end
    end
    tick();
    mem_busy = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'd16) begin errors++; $display("FAIL busy_resume: got read %0b addr %h want 1 00000010", mem_read, mem_addr); end
    tick(); #1;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd16) begin errors++; $display("FAIL busy_after: got v %0b pc %h want 1 00000010", instr_valid, instr_pc); end
    checks++; if (mem_addr !== 32'd20) begin errors++; $display("FAIL busy_next_addr: got %h want 00000014", mem_addr); end
  endtask

  task automatic test_redirect;
    instr_ready = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL redir_fill: got %0b want 1", mem_read); end
    tick(); #1;
    checks++; if (mem_read !== 1'b0 || mem_addr !== 32'd24) begin errors++; $display("FAIL redir_full: got read %0b addr %h want 0 00000018", mem_read, mem_addr); end
    redirect = 1'b1; redirect_pc = 32'd32;
    #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL redir_read: got %0b want 0", mem_read); end
    tick();
    redirect = 1'b0; instr_ready = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %0b want 0", instr_valid); end
    checks++; if (mem_addr !== 32'd32 || mem_read !== 1'b1) begin errors++; $display("FAIL redir_addr: got addr %h read %0b want 00000020 1", mem_addr, mem_read); end
    tick(); #1;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd32) begin errors++; $display("FAIL redir_pc: got v %0b pc %h want 1 00000020", instr_valid, instr_pc); end
    checks++; if (instr !== (32'd32 ^ 32'hA5A50000)) begin errors++; $display("FAIL redir_instr: got %h want %h", instr, 32'd32 ^ 32'hA5A50000); end
  endtask

  task automatic test_wrap;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL wrap_redir_read: got %0b want 0", mem_read); end
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (mem_addr !== 32'hFFFF_FFFC || mem_read !== 1'b1) begin errors++; $display("FAIL wrap_align: got addr %h read %0b want fffffffc 1", mem_addr, mem_read); end
    tick(); #1;
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", mem_addr); end
    checks++; if (instr_pc !== 32'hFFFF_FFFC || instr !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap_head: got pc %h instr %h want fffffffc 5a5afffc", instr_pc, instr); end
    tick(); #1;
    checks++; if (instr_pc !== 32'h0 || instr !== 32'hA5A5_0000 || mem_addr !== 32'd4) begin errors++; $display("FAIL wrap_next: got pc %h instr %h addr %h want 0 a5a50000 4", instr_pc, instr, mem_addr); end
  endtask

  task automatic test_async_reset;
    instr_ready = 1'b0;
    tick(); #1;
    checks++; if (instr_valid !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL ares_full: got v %0b read %0b want 1 0", instr_valid, mem_read); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL ares_async: got v %0b read %0b want 0 0", instr_valid, mem_read); end
    checks++; if (mem_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL ares_outs: got addr %h instr %h pc %h want 0 0 0", mem_addr, instr, instr_pc); end
    tick();
    rst_n = 1'b1; instr_ready = 1'b1;
    #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL ares_boot: got %0b want 0", mem_read); end
    tick(); #1;
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL ares_first: got read %0b addr %h want 1 00000000", mem_read, mem_addr); end
  endtask

  task automatic test_backpressure;
    rst_n = 1'b0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL bp_boot: got %0b want 0", mem_read); end
    tick(); #1;
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL bp_push0: got read %0b addr %h want 1 0", mem_read, mem_addr); end
    tick(); #1;
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'd4) begin errors++; $display("FAIL bp_push1: got read %0b addr %h want 1 4", mem_read, mem_addr); end
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      checks++; if (mem_read !== 1'b0 || mem_addr !== 32'd8) begin errors++; $display("FAIL bp_stall%0d: got read %0b addr %h want 0 8", k, mem_read, mem_addr); end
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL bp_head%0d: got v %0b pc %h want 1 0", k, instr_valid, instr_pc); end
    end
    instr_ready = 1'b1;
    #1;
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'd8) begin errors++; $display("FAIL bp_refetch: got read %0b addr %h want 1 8", mem_read, mem_addr); end
    checks++; if (instr !== 32'hA5A5_0000) begin errors++; $display("FAIL bp_pop_instr: got %h want a5a50000", instr); end
    tick(); #1;
    checks++; if (instr_pc !== 32'd4 || mem_read !== 1'b1 || mem_addr !== 32'd12) begin errors++; $display("FAIL bp_next: got pc %h read %0b addr %h want 4 1 c", instr_pc, mem_read, mem_addr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_mem_busy();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_backpressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
